// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default
// geometry, fetch address field positions and the fill FSM state encoding.
package icache_pkg;

  localparam int NUM_LINES  = 4;
  localparam int LINE_WORDS = 4;

  localparam int OFFSET_LSB = 2;
  localparam int OFFSET_MSB = 3;
  localparam int INDEX_LSB  = 4;
  localparam int INDEX_MSB  = 5;
  localparam int TAG_LSB    = 6;
  localparam int TAG_MSB    = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } fillState_e;

endpackage

// File: rtl/icache_fill_ctrl.sv
// Line-fill controller: owns the miss FSM, the beat counter, the kill flag
// that suppresses validation of a fill invalidated while in flight, and the
// latched line address of the outstanding miss.
module icache_fill_ctrl #(
  parameter int LINE_WORDS = icache_pkg::LINE_WORDS,
  parameter int OFF_BITS   = $clog2(LINE_WORDS)
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [31:0]         lineAddr,
  input  logic                lookupMiss,
  input  logic                invalidate,
  input  logic                memAck,
  input  logic                memValid,
  output logic                idle,
  output logic                memReq,
  output logic                beatWrite,
  output logic                lastBeat,
  output logic                kill,
  output logic [OFF_BITS-1:0] beatCount,
  output logic [31:0]         missAddr
);
  import icache_pkg::*;

  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

  fillState_e          state;
  fillState_e          stateNext;
  logic [OFF_BITS-1:0] countNext;
  logic                killNext;
  logic [31:0]         missAddrNext;

  // Register the FSM state and the fill bookkeeping; reset abandons any fill.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      beatCount <= '0;
      kill      <= 1'b0;
      missAddr  <= '0;
    end else begin
      state     <= stateNext;
      beatCount <= countNext;
      kill      <= killNext;
      missAddr  <= missAddrNext;
    end
  end

  // Next-state and handshake decode; memory beats only count while in FILL.
  always_comb begin
    stateNext    = state;
    countNext    = beatCount;
    killNext     = kill;
    missAddrNext = missAddr;
    memReq       = 1'b0;
    beatWrite    = 1'b0;
    lastBeat     = 1'b0;
    case (state)
      IDLE: begin
        if (lookupMiss) begin
          missAddrNext = lineAddr;
          stateNext    = REQ;
        end
      end
      REQ: begin
        memReq = 1'b1;
        if (memAck) begin
          stateNext = FILL;
          countNext = '0;
        end
      end
      FILL: begin
        if (memValid) begin
          beatWrite = 1'b1;
          countNext = beatCount + OFF_BITS'(1);
          if (beatCount == LAST_BEAT) begin
            lastBeat  = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    if (invalidate && (state != IDLE)) begin
      killNext = 1'b1;
    end
    if (lastBeat) begin
      killNext = 1'b0;
    end
    if (rst) begin
      memReq    = 1'b0;
      beatWrite = 1'b0;
      lastBeat  = 1'b0;
    end
    idle = (state == IDLE);
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with a zero-latency hit path; tag, valid
// and data storage live here, miss handling is delegated to the fill controller.
module icache #(
  parameter int NUM_LINES  = icache_pkg::NUM_LINES,
  parameter int LINE_WORDS = icache_pkg::LINE_WORDS
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        rd_en,
  input  logic        invalidate,
  output logic [31:0] instruction,
  output logic        hit,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);
  import icache_pkg::*;

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int IDX_BASE = OFFSET_LSB + OFF_BITS;
  localparam int TAG_BASE = IDX_BASE + IDX_BITS;
  localparam int TAG_BITS = 32 - TAG_BASE;

  logic [OFF_BITS-1:0] pcOffset;
  logic [IDX_BITS-1:0] pcIndex;
  logic [TAG_BITS-1:0] pcTag;
  logic [IDX_BITS-1:0] missIndex;
  logic [TAG_BITS-1:0] missTag;
  logic [31:0]         lineAddr;
  logic [31:0]         missAddr;
  logic [OFF_BITS-1:0] beatCount;
  logic                fillIdle;
  logic                lookupMiss;
  logic                beatWrite;
  logic                lastBeat;
  logic                kill;
  logic                unusedPcBits;

  logic [NUM_LINES-1:0] validBits;
  logic [TAG_BITS-1:0]  tagArray  [NUM_LINES];
  logic [31:0]          dataArray [NUM_LINES][LINE_WORDS];

  assign pcOffset     = pc[IDX_BASE-1:OFFSET_LSB];
  assign pcIndex      = pc[TAG_BASE-1:IDX_BASE];
  assign pcTag        = pc[31:TAG_BASE];
  assign lineAddr     = {pc[31:IDX_BASE], {IDX_BASE{1'b0}}};
  assign missIndex    = missAddr[TAG_BASE-1:IDX_BASE];
  assign missTag      = missAddr[31:TAG_BASE];
  assign unusedPcBits = ^pc[OFFSET_LSB-1:0];

  assign lookupMiss = rd_en && !hit;
  assign stall      = !rst && (!fillIdle || lookupMiss);
  assign mem_addr   = missAddr;

  icache_fill_ctrl #(
    .LINE_WORDS (LINE_WORDS),
    .OFF_BITS   (OFF_BITS)
  ) fillCtrl (
    .clock      (clock),
    .rst        (rst),
    .lineAddr   (lineAddr),
    .lookupMiss (lookupMiss),
    .invalidate (invalidate),
    .memAck     (mem_ack),
    .memValid   (mem_valid),
    .idle       (fillIdle),
    .memReq     (mem_req),
    .beatWrite  (beatWrite),
    .lastBeat   (lastBeat),
    .kill       (kill),
    .beatCount  (beatCount),
    .missAddr   (missAddr)
  );

  // Zero-latency lookup: only an idle cache with a requested, valid, matching line hits.
  always_comb begin
    hit         = 1'b0;
    instruction = 32'h0;
    if (!rst && fillIdle && rd_en && validBits[pcIndex] && (tagArray[pcIndex] == pcTag)) begin
      hit         = 1'b1;
      instruction = dataArray[pcIndex][pcOffset];
    end
  end

  // Valid bits: invalidate beats a completing fill, and a killed fill never validates.
  always_ff @(posedge clock) begin
    if (rst) begin
      validBits <= '0;
    end else if (invalidate) begin
      validBits <= '0;
    end else if (lastBeat && !kill) begin
      validBits[missIndex] <= 1'b1;
    end
  end

  // Data and tag storage are left unreset; the valid bits alone qualify them.
  always_ff @(posedge clock) begin
    if (beatWrite) begin
      dataArray[missIndex][beatCount] <= mem_data;
    end
    if (lastBeat) begin
      tagArray[missIndex] <= missTag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized run
// against a line-level model of cache contents.
module tb_icache;

  localparam int LINE_WORDS = 4;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        rd_en;
  logic        invalidate;
  logic [31:0] instruction;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_valid;
  logic [31:0] mem_data;

  int compared   = 0;
  int mismatched = 0;

  icache dut (
    .clock       (clock),
    .rst         (rst),
    .pc          (pc),
    .rd_en       (rd_en),
    .invalidate  (invalidate),
    .instruction (instruction),
    .hit         (hit),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_valid   (mem_valid),
    .mem_data    (mem_data)
  );

  // Free-running clock; inputs change and outputs are sampled around the falling edge.
  always #5 clock = ~clock;

  // Backing memory contents: line 0x40 holds 0xA0..0xA3, everything else is address-derived.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] line;
    line = {addr[31:4], 4'h0};
    if (line == 32'h40) return 32'hA0 + {30'h0, addr[3:2]};
    return 32'hC0DE_1000 ^ {addr[31:2], 2'b00};
  endfunction

  // Plays the memory side of one line fill; reports what it observed.
  task automatic serveFill(input int ackDelay, input int gapAfter, input int gapLen,
                           input int invAtBeat, input bit strayInReq,
                           output logic [31:0] seenAddr, output bit reqSeen,
                           output bit reqLowInFill, output bit stallHeld);
    reqSeen = 1'b0; reqLowInFill = 1'b1; stallHeld = 1'b1; seenAddr = '0;
    for (int i = 0; i < 20 && !reqSeen; i++) begin
      @(negedge clock); invalidate = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0; #1;
      if (mem_req === 1'b1) begin reqSeen = 1'b1; seenAddr = mem_addr; end
    end
    if (!reqSeen) return;
    for (int i = 0; i < ackDelay; i++) begin
      @(negedge clock); mem_valid = strayInReq; mem_data = $urandom; #1;
      stallHeld &= (stall === 1'b1);
    end
    @(negedge clock); mem_ack = 1'b1; mem_valid = strayInReq; mem_data = $urandom; #1;
    stallHeld &= (stall === 1'b1);
    for (int b = 0; b < LINE_WORDS; b++) begin
      if (b == gapAfter) begin
        for (int g = 0; g < gapLen; g++) begin
          @(negedge clock); mem_ack = 1'b0; mem_valid = 1'b0; invalidate = 1'b0; mem_data = $urandom; #1;
          stallHeld &= (stall === 1'b1); reqLowInFill &= (mem_req === 1'b0);
        end
      end
      @(negedge clock);
      mem_ack = 1'b0; mem_valid = 1'b1; invalidate = (b == invAtBeat);
      mem_data = memWord({seenAddr[31:4], b[1:0], 2'b00}); #1;
      stallHeld &= (stall === 1'b1); reqLowInFill &= (mem_req === 1'b0);
    end
    @(negedge clock); mem_valid = 1'b0; invalidate = 1'b0; mem_data = $urandom; #1;
  endtask

  // Outputs forced quiet during reset, and an idle cache with no request afterwards.
  task automatic test_reset;
    @(negedge clock);
    rst = 1'b1; pc = 32'h40; rd_en = 1'b1; invalidate = 1'b1; mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF; #1;
    compared++; if (hit !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hit: got %b expected 0", hit); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    compared++; if (instruction !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_instr: got %h expected 0", instruction); end
    @(negedge clock);
    @(negedge clock); rst = 1'b0; rd_en = 1'b0; invalidate = 1'b0; mem_valid = 1'b0; #1;
    compared++; if (stall !== 1'b0 || hit !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_quiet: got stall=%b hit=%b expected 0/0", stall, hit); end
    compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    @(negedge clock); #1;
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_no_fill: got %b expected 0", mem_req); end
  endtask

  // First fetch misses, fills from 0x40, then hits on the held PC.
  task automatic test_cold_miss;
    logic [31:0] sa; bit rs, rl, sh;
    @(negedge clock); pc = 32'h40; rd_en = 1'b1; #1;
    compared++; if (stall !== 1'b1 || hit !== 1'b0) begin mismatched++; $display("[TB] FAIL cold_miss: got stall=%b hit=%b expected 1/0", stall, hit); end
    serveFill(1, 9, 0, -1, 1'b0, sa, rs, rl, sh);
    compared++; if (sa !== 32'h40) begin mismatched++; $display("[TB] FAIL cold_mem_addr: got %h expected 00000040", sa); end
    compared++; if (!(rl && sh)) begin mismatched++; $display("[TB] FAIL cold_handshake: got req_low=%b stall_held=%b expected 1/1", rl, sh); end
    compared++; if (hit !== 1'b1 || stall !== 1'b0) begin mismatched++; $display("[TB] FAIL cold_refetch: got hit=%b stall=%b expected 1/0", hit, stall); end
    compared++; if (instruction !== 32'hA0) begin mismatched++; $display("[TB] FAIL cold_instr: got %h expected 000000a0", instruction); end
  endtask

  // Remaining words of the freshly filled line hit with no stall.
  task automatic test_same_line_hits;
    for (int w = 1; w < 4; w++) begin
      @(negedge clock); pc = 32'h40 + 32'(4 * w); rd_en = 1'b1; #1;
      compared++; if (hit !== 1'b1 || stall !== 1'b0) begin mismatched++; $display("[TB] FAIL line_hit_%0d: got hit=%b stall=%b expected 1/0", w, hit, stall); end
      compared++; if (instruction !== 32'hA0 + 32'(w)) begin mismatched++; $display("[TB] FAIL line_instr_%0d: got %h expected %h", w, instruction, 32'hA0 + 32'(w)); end
    end
  endtask

  // 0x80 evicts 0x40 from the shared index; 0x40 then misses and refills.
  task automatic test_conflict;
    logic [31:0] sa; bit rs, rl, sh;
    @(negedge clock); pc = 32'h80; rd_en = 1'b1; #1;
    compared++; if (hit !== 1'b0 || stall !== 1'b1) begin mismatched++; $display("[TB] FAIL conflict_miss: got hit=%b stall=%b expected 0/1", hit, stall); end
    serveFill(0, 9, 0, -1, 1'b1, sa, rs, rl, sh);
    compared++; if (sa !== 32'h80) begin mismatched++; $display("[TB] FAIL conflict_addr: got %h expected 00000080", sa); end
    compared++; if (hit !== 1'b1 || instruction !== memWord(32'h80)) begin mismatched++; $display("[TB] FAIL conflict_fill: got hit=%b instr=%h expected 1/%h", hit, instruction, memWord(32'h80)); end
    @(negedge clock); pc = 32'h40; #1;
    compared++; if (hit !== 1'b0 || stall !== 1'b1) begin mismatched++; $display("[TB] FAIL evicted_miss: got hit=%b stall=%b expected 0/1", hit, stall); end
    serveFill(2, 9, 0, -1, 1'b0, sa, rs, rl, sh);
    compared++; if (sa !== 32'h40 || hit !== 1'b1 || instruction !== 32'hA0) begin mismatched++; $display("[TB] FAIL refill_40: got addr=%h hit=%b instr=%h expected 00000040/1/000000a0", sa, hit, instruction); end
  endtask

  // Two idle cycles between beats 1 and 2 must not disturb the fill.
  task automatic test_gapped_beats;
    logic [31:0] sa; bit rs, rl, sh;
    @(negedge clock); pc = 32'h50; rd_en = 1'b1; #1;
    serveFill(1, 2, 2, -1, 1'b0, sa, rs, rl, sh);
    compared++; if (!(rs && rl && sh)) begin mismatched++; $display("[TB] FAIL gap_stall: got req=%b req_low=%b stall_held=%b expected 1/1/1", rs, rl, sh); end
    for (int w = 0; w < 4; w++) begin
      @(negedge clock); pc = 32'h50 + 32'(4 * w); #1;
      compared++; if (hit !== 1'b1 || instruction !== memWord(pc)) begin mismatched++; $display("[TB] FAIL gap_word_%0d: got hit=%b instr=%h expected 1/%h", w, hit, instruction, memWord(pc)); end
    end
  endtask

  // Invalidate mid-fill and on the last beat leaves the line invalid; in IDLE it drops hits.
  task automatic test_invalidate;
    logic [31:0] sa; bit rs, rl, sh;
    @(negedge clock); pc = 32'h60; rd_en = 1'b1; #1;
    serveFill(0, 9, 0, 1, 1'b0, sa, rs, rl, sh);
    compared++; if (hit !== 1'b0 || stall !== 1'b1) begin mismatched++; $display("[TB] FAIL kill_mid: got hit=%b stall=%b expected 0/1", hit, stall); end
    serveFill(0, 9, 0, -1, 1'b0, sa, rs, rl, sh);
    compared++; if (hit !== 1'b1 || instruction !== memWord(32'h60)) begin mismatched++; $display("[TB] FAIL kill_recover: got hit=%b instr=%h expected 1/%h", hit, instruction, memWord(32'h60)); end
    @(negedge clock); pc = 32'h74; #1;
    serveFill(1, 9, 0, 3, 1'b0, sa, rs, rl, sh);
    compared++; if (hit !== 1'b0 || stall !== 1'b1) begin mismatched++; $display("[TB] FAIL kill_last: got hit=%b stall=%b expected 0/1", hit, stall); end
    serveFill(1, 9, 0, -1, 1'b0, sa, rs, rl, sh);
    compared++; if (hit !== 1'b1 || instruction !== memWord(32'h74)) begin mismatched++; $display("[TB] FAIL last_recover: got hit=%b instr=%h expected 1/%h", hit, instruction, memWord(32'h74)); end
    @(negedge clock); rd_en = 1'b0; invalidate = 1'b1; #1;
    compared++; if (hit !== 1'b0 || stall !== 1'b0) begin mismatched++; $display("[TB] FAIL inv_idle: got hit=%b stall=%b expected 0/0", hit, stall); end
    @(negedge clock); invalidate = 1'b0; rd_en = 1'b1; pc = 32'h74; #1;
    compared++; if (hit !== 1'b0 || stall !== 1'b1) begin mismatched++; $display("[TB] FAIL inv_idle_miss: got hit=%b stall=%b expected 0/1", hit, stall); end
    serveFill(0, 9, 0, -1, 1'b0, sa, rs, rl, sh);
  endtask

  // Reset after two beats abandons the fill; later beats are ignored.
  task automatic test_reset_mid_fill;
    logic [31:0] sa; bit rs, rl, sh; bit seen;
    seen = 1'b0;
    @(negedge clock); pc = 32'h40; rd_en = 1'b1; #1;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clock); #1; seen = (mem_req === 1'b1); end
    compared++; if (!seen) begin mismatched++; $display("[TB] FAIL rmf_req: got 0 expected 1"); end
    @(negedge clock); mem_ack = 1'b1;
    @(negedge clock); mem_ack = 1'b0; mem_valid = 1'b1; mem_data = 32'hA0;
    @(negedge clock); mem_data = 32'hA1;
    @(negedge clock); mem_valid = 1'b0; rst = 1'b1; #1;
    compared++; if (mem_req !== 1'b0 || stall !== 1'b0 || hit !== 1'b0) begin mismatched++; $display("[TB] FAIL rmf_during: got req=%b stall=%b hit=%b expected 0/0/0", mem_req, stall, hit); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); rst = 1'b0; rd_en = 1'b0; mem_valid = 1'b1; mem_data = 32'hDEAD_0000 + 32'(i); #1;
      compared++; if (mem_req !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL rmf_stray_%0d: got req=%b stall=%b addr=%h expected 0/0/0", i, mem_req, stall, mem_addr); end
    end
    @(negedge clock); mem_valid = 1'b0; pc = 32'h40; rd_en = 1'b1; #1;
    compared++; if (hit !== 1'b0 || stall !== 1'b1) begin mismatched++; $display("[TB] FAIL rmf_miss: got hit=%b stall=%b expected 0/1", hit, stall); end
    serveFill(0, 9, 0, -1, 1'b0, sa, rs, rl, sh);
    compared++; if (sa !== 32'h40 || hit !== 1'b1 || instruction !== 32'hA0) begin mismatched++; $display("[TB] FAIL rmf_refill: got addr=%h hit=%b instr=%h expected 00000040/1/000000a0", sa, hit, instruction); end
  endtask

  // Random fetches, invalidates and fill timing against a line-contents model.
  task automatic test_random;
    bit          mValid [4];
    logic [25:0] mTag   [4];
    logic [31:0] mData  [4][4];
    @(negedge clock); rst = 1'b1; rd_en = 1'b0; invalidate = 1'b0; mem_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clock); rst = 1'b0;
    for (int i = 0; i < 4; i++) mValid[i] = 1'b0;
    for (int it = 0; it < 80; it++) begin
      logic [31:0] p; logic [31:0] sa; bit re, inv, expHit, rs, rl, sh, killed; int idx, off, invBeat, tries;
      p = $urandom_range(0, 255);
      re = ($urandom_range(0, 9) < 8);
      inv = ($urandom_range(0, 9) == 0);
      idx = int'(p[5:4]); off = int'(p[3:2]);
      expHit = re && mValid[idx] && (mTag[idx] == p[31:6]);
      @(negedge clock); pc = p; rd_en = re; invalidate = inv; mem_valid = 1'b0; mem_ack = 1'b0; #1;
      compared++; if (hit !== expHit || stall !== (re && !expHit)) begin mismatched++; $display("[TB] FAIL rnd_lookup_%0d: got hit=%b stall=%b expected %b/%b", it, hit, stall, expHit, re && !expHit); end
      compared++; if (instruction !== (expHit ? mData[idx][off] : 32'h0)) begin mismatched++; $display("[TB] FAIL rnd_instr_%0d: got %h expected %h", it, instruction, expHit ? mData[idx][off] : 32'h0); end
      if (inv) for (int i = 0; i < 4; i++) mValid[i] = 1'b0;
      if (re && !expHit) begin
        killed = 1'b1; tries = 0;
        while (killed) begin
          invBeat = (tries == 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
          serveFill(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                    invBeat, 1'($urandom_range(0, 1)), sa, rs, rl, sh);
          compared++; if (sa !== {p[31:4], 4'h0} || !(rl && sh)) begin mismatched++; $display("[TB] FAIL rnd_fill_%0d: got addr=%h req_low=%b stall_held=%b expected %h/1/1", it, sa, rl, sh, {p[31:4], 4'h0}); end
          mTag[idx] = p[31:6];
          for (int w = 0; w < 4; w++) mData[idx][w] = memWord({p[31:4], 4'h0} + 32'(4 * w));
          killed = (invBeat >= 0);
          if (killed) for (int i = 0; i < 4; i++) mValid[i] = 1'b0;
          else mValid[idx] = 1'b1;
          compared++; if (hit !== !killed || instruction !== (killed ? 32'h0 : mData[idx][off])) begin mismatched++; $display("[TB] FAIL rnd_after_%0d: got hit=%b instr=%h expected %b/%h", it, hit, instruction, !killed, killed ? 32'h0 : mData[idx][off]); end
          tries++;
        end
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b1; pc = '0; rd_en = 1'b0; invalidate = 1'b0;
    mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
    test_reset();
    test_cold_miss();
    test_same_line_hits();
    test_conflict();
    test_gapped_beats();
    test_invalidate();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be, in this order:
- clock  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  fetch byte address.
- rd_en  in  1  fetch requests an instruction this cycle.
- invalidate  in  1  clear all valid bits.
- instruction  out  32  fetched word; 32'h0 when hit=0.
- hit  out  1  instruction is valid this cycle.
- stall  out  1  hold PC and IF/ID registers.
- mem_req  out  1  line-fill request to main memory.
- mem_addr  out  32  line-aligned fill address.
- mem_ack  in  1  memory accepted the request.
- mem_valid  in  1  data beat valid.
- mem_data  in  32  data beat.
REQ-003 Parameters SHALL be:
- NUM_LINES, default 4, number of direct-mapped lines.
- LINE_WORDS, default 4, words per line.

Function
REQ-004 Address split SHALL be: pc[1:0] ignored; offset pc[3:2]; index pc[5:4]; tag pc[31:6].
REQ-005 The states SHALL be IDLE, REQ and FILL.
REQ-006 Hit SHALL be combinational (zero latency): hit=1 only when state=IDLE, rd_en=1, valid[index]=1 and tag[index]=pc tag; instruction then equals data[index][offset] in the same cycle.
REQ-007 stall SHALL equal (state!=IDLE) OR (rd_en AND NOT hit).
REQ-008 In IDLE with rd_en=1 and a miss, the block SHALL latch miss_addr={pc[31:4],4'b0} and go to REQ at the next edge.
REQ-009 In IDLE with rd_en=0, the block SHALL output hit=0, stall=0 and start no fill.
REQ-010 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal miss_addr; on mem_ack=1 the block SHALL go to FILL with the beat counter at 0, and mem_req SHALL be 0 from the next cycle.
REQ-011 mem_addr SHALL hold miss_addr in every state; mem_req SHALL be 0 outside REQ.
REQ-012 In FILL, each cycle with mem_valid=1 SHALL write mem_data to data[miss index][counter] and increment the 2-bit counter.
REQ-013 The beat with counter=3 SHALL write the tag, set the valid bit unless kill is set, clear kill and return to IDLE.
REQ-014 In FILL, cycles with mem_valid=0 SHALL leave state and counter unchanged.
REQ-015 mem_valid in IDLE or REQ SHALL be ignored.
REQ-016 invalidate=1 SHALL clear all valid bits at the edge in any state.
REQ-017 invalidate=1 in REQ or FILL SHALL set kill, so the in-flight fill completes without being validated.
REQ-018 invalidate coincident with the final beat SHALL leave that line invalid.
REQ-019 Because the PC is held by stall, the first IDLE cycle after a fill SHALL hit.
REQ-020 Miss penalty SHALL be 1 cycle + mem_ack wait + 4 valid beats.

Reset
REQ-021 On rst=1 at an edge, the block SHALL set state=IDLE, all valid bits=0, kill=0, counter=0 and miss_addr=0.
REQ-022 Outputs during reset SHALL be: mem_req=0, hit=0, stall=0, instruction=32'h0.
REQ-023 The data and tag arrays SHALL NOT be reset.
REQ-024 Reset mid-REQ or mid-FILL SHALL abandon the fill; later mem_valid beats SHALL be ignored.
REQ-025 rst SHALL take priority over invalidate and mem_valid.

Structure
REQ-026 Shared package icache_pkg SHALL hold: the state encoding (IDLE=0, REQ=1, FILL=2), NUM_LINES, LINE_WORDS, and the offset/index/tag bit positions.
REQ-027 Sub-module icache_fill_ctrl SHALL hold the FSM, beat counter, kill flag and miss_addr; the tag, valid and data arrays plus hit logic SHALL stay in icache.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Cold miss: after reset, pc=0x40, rd_en=1 -> stall=1, mem_req with mem_addr=0x40; ack; beats 0xA0..0xA3 -> next cycle hit=1, instruction=0xA0.
- Same-line hits: after the fill, pc=0x44/0x48/0x4C -> hit=1, stall=0, instruction=0xA1/0xA2/0xA3.
- Conflict: pc=0x80 (same index as 0x40, new tag) -> miss and refill; then pc=0x40 misses again.
- Gapped beats: mem_valid low 2 cycles between beats 1 and 2 -> all 4 words correct, stall held throughout.
- Invalidate: invalidate during FILL -> fill ends, next cycle still misses; invalidate in IDLE -> previous hits miss.
- Reset mid-FILL after 2 beats -> IDLE, mem_req=0, stray mem_valid ignored, pc=0x40 misses.
